bit_debouncers: RTL and testbench

Per-bit debouncer bank for slow external inputs such as buttons and switches. It sits directly downstream of the bit_synchronizers stage and consumes its already-synchronized bits_out. Each bit gets a stable level plus one-cycle rise/fall event pulses. A bit's stable level changes only after its input has held a new value for STABLE_CYCLES consecutive clocks.

---
 rtl/bit_debouncer.sv | 58 +++++
 rtl/bit_debouncers.sv | 31 +++
 tb/tb_bit_debouncers.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bit_debouncer.sv
// Single-bit debouncer: accepts a new level only after STABLE_CYCLES
// consecutive samples that differ from the current stable level, and
// emits one-cycle rise/fall pulses when the level changes.
module bit_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic bit_in,
  output logic bit_out,
  output logic rise_out,
  output logic fall_out
);

  // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit.
  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_d;
  logic          rise_d;
  logic          fall_d;

  // Next-state: restart on agreement, count on disagreement, accept at the limit.
  always_comb begin
    cnt_d   = '0;
    level_d = bit_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bit_in != bit_out) begin
      if (cnt_q == CNT_MAX) begin
        level_d = bit_in;
        rise_d  = bit_in;
        fall_d  = ~bit_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State, level and pulse registers; reset discards any partial count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q    <= '0;
      bit_out  <= RESET_LEVEL;
      rise_out <= 1'b0;
      fall_out <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_out  <= level_d;
      rise_out <= rise_d;
      fall_out <= fall_d;
    end
  end

endmodule

// File: rtl/bit_debouncers.sv
// Bank of WIDTH independent single-bit debouncers fed from the
// synchronizer stage.
module bit_debouncers #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] bits_in,
  output logic [WIDTH-1:0] bits_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  // One debouncer per bit; no cross-bit interaction.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    bit_debouncer #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL[i])
    ) u_deb (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bit_in   (bits_in[i]),
      .bit_out  (bits_out[i]),
      .rise_out (rise_out[i]),
      .fall_out (fall_out[i])
    );
  end

endmodule

// File: tb/tb_bit_debouncers.sv
// Bench for bit_debouncers: two configurations (4-cycle and 1-cycle filters)
// compared against a sample-history reference model.
module tb_bit_debouncers;

  localparam int unsigned SCA = 4;
  localparam int unsigned SCB = 1;
  localparam logic [1:0]  RLA = 2'b10;
  localparam logic [2:0]  RLB = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_a = '0;
  logic [1:0] a_out, a_rise, a_fall;
  logic [2:0] in_b = '0;
  logic [2:0] b_out, b_rise, b_fall;

  int errors = 0;
  int checks = 0;

  // Expected outputs and recent sample history per DUT.
  logic [1:0] ea_out = RLA, ea_rise = '0, ea_fall = '0;
  logic [2:0] eb_out = RLB, eb_rise = '0, eb_fall = '0;
  logic [1:0] qa[$];
  logic [2:0] qb[$];

  always #5 clk = ~clk;

  bit_debouncers #(.WIDTH(2), .STABLE_CYCLES(SCA), .RESET_LEVEL(RLA)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bits_in(in_a),
    .bits_out(a_out), .rise_out(a_rise), .fall_out(a_fall));

  bit_debouncers #(.WIDTH(3), .STABLE_CYCLES(SCB), .RESET_LEVEL(RLB)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bits_in(in_b),
    .bits_out(b_out), .rise_out(b_rise), .fall_out(b_fall));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ea_out = RLA; ea_rise = '0; ea_fall = '0;
    eb_out = RLB; eb_rise = '0; eb_fall = '0;
  endtask

  // A bit flips when its last SC samples all disagree with its stable level.
  task automatic model_edge();
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    qa.push_back(in_a);
    if (qa.size() > SCA) void'(qa.pop_front());
    qb.push_back(in_b);
    if (qb.size() > SCB) void'(qb.pop_front());
    ea_rise = '0; ea_fall = '0;
    eb_rise = '0; eb_fall = '0;
    for (int i = 0; i < 2; i++) begin
      all_diff = (qa.size() == SCA);
      foreach (qa[k]) if (qa[k][i] == ea_out[i]) all_diff = 1'b0;
      if (all_diff) begin
        ea_out[i] = in_a[i]; ea_rise[i] = in_a[i]; ea_fall[i] = ~in_a[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      all_diff = (qb.size() == SCB);
      foreach (qb[k]) if (qb[k][i] == eb_out[i]) all_diff = 1'b0;
      if (all_diff) begin
        eb_out[i] = in_b[i]; eb_rise[i] = in_b[i]; eb_fall[i] = ~in_b[i];
      end
    end
  endtask

  task automatic compare_all();
    chk("a_out", 32'(a_out), 32'(ea_out));
    chk("a_rise", 32'(a_rise), 32'(ea_rise));
    chk("a_fall", 32'(a_fall), 32'(ea_fall));
    chk("b_out", 32'(b_out), 32'(eb_out));
    chk("b_rise", 32'(b_rise), 32'(eb_rise));
    chk("b_fall", 32'(b_fall), 32'(eb_fall));
    chk("a_pulse_excl", 32'(a_rise & a_fall), 32'd0);
    chk("b_pulse_excl", 32'(b_rise & b_fall), 32'd0);
  endtask

  // One clock: update model at the edge, sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset_pulse();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_a_out", 32'(a_out), 32'(RLA));
    chk("async_a_pulses", 32'({a_rise, a_fall}), 32'd0);
    chk("async_b_out", 32'(b_out), 32'(RLB));
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with inputs toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_a = 2'($urandom);
      in_b = 3'($urandom);
      step();
      chk("rst_a_out", 32'(a_out), 32'(2'b10));
      chk("rst_a_pulses", 32'({a_rise, a_fall}), 32'd0);
    end
    rst_n = 1'b1;
    in_a = 2'b10;
    in_b = 3'b000;
    step();
    step();

    // Glitch: three samples of 1 then back to 0 must be rejected.
    in_a = 2'b11;
    in_b = 3'b001;
    step();
    chk("b_sc1_rise", 32'({b_out, b_rise}), 32'({3'b001, 3'b001}));
    in_b = 3'b000;
    step();
    chk("b_sc1_fall", 32'({b_out, b_fall}), 32'({3'b000, 3'b001}));
    step();
    in_a = 2'b10;
    step();
    chk("glitch_out", 32'(a_out), 32'(2'b10));
    chk("glitch_rise", 32'(a_rise), 32'd0);

    // Clean edge: held for four edges, accepted on the fourth.
    in_a = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("edge_wait", 32'(a_out), 32'(2'b10));
    end
    step();
    chk("edge_out", 32'(a_out), 32'(2'b11));
    chk("edge_rise", 32'(a_rise), 32'(2'b01));
    step();
    chk("edge_rise_done", 32'(a_rise), 32'd0);

    // Back to 10, then 01: bit0 rises and bit1 falls in the same cycle.
    in_a = 2'b10;
    repeat (4) step();
    chk("back_out", 32'(a_out), 32'(2'b10));
    in_a = 2'b01;
    repeat (4) step();
    chk("swap_out", 32'(a_out), 32'(2'b01));
    chk("swap_rise", 32'(a_rise), 32'(2'b01));
    chk("swap_fall", 32'(a_fall), 32'(2'b10));
    step();
    chk("swap_done", 32'({a_rise, a_fall}), 32'd0);

    // Reset mid-count discards the partial count.
    in_a = 2'b10;
    repeat (4) step();
    in_a = 2'b11;
    step();
    step();
    async_reset_pulse();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wait", 32'(a_out), 32'(2'b10));
    end
    step();
    chk("post_rst_out", 32'(a_out), 32'(2'b11));
    chk("post_rst_rise", 32'(a_rise), 32'(2'b01));

    // Randomized traffic; A flips bits rarely so levels actually settle.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 5) == 0) in_a[i] = ~in_a[i];
      in_b = 3'($urandom);
      if (n % 150 == 149) async_reset_pulse();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
